// File: rtl/nv_nvdla_reset_seq.sv
// Partition reset sequencer: quiesce, assert all partition resets, hold, then staged in-order release.
// All outputs registered; soft-reset requests arriving while busy are dropped, not queued.
module nv_nvdla_reset_seq #(
  parameter int NUM_PART = 4,
  parameter int DLY_W    = 8,
  parameter int HOLD_CYC = 16
) (
  input  logic                nvdla_clk,
  input  logic                dla_reset,
  input  logic                sw_rst_req,
  input  logic [DLY_W-1:0]    cfg_rel_dly,
  input  logic [DLY_W-1:0]    cfg_qto,
  input  logic [NUM_PART-1:0] part_idle,
  output logic [NUM_PART-1:0] part_rstn,
  output logic                sw_rst_ack,
  output logic                seq_busy,
  output logic                qto_err
);

  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int IDX_W  = (NUM_PART > 1) ? $clog2(NUM_PART) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_PART - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIESCE,
    S_ASSERT,
    S_HOLD,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_PART-1:0] part_rstn_q, part_rstn_d;
  logic                sw_rst_ack_q, sw_rst_ack_d;
  logic                seq_busy_q, seq_busy_d;
  logic                qto_err_q, qto_err_d;
  logic                sw_flag_q, sw_flag_d;
  logic [DLY_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DLY_W-1:0]    rel_cnt_q, rel_cnt_d;
  logic [DLY_W-1:0]    rel_dly_q, rel_dly_d;
  logic [IDX_W-1:0]    rel_idx_q, rel_idx_d;
  logic [DLY_W-1:0]    wait_inc;

  always_comb begin
    state_d      = state_q;
    part_rstn_d  = part_rstn_q;
    sw_rst_ack_d = 1'b0;
    qto_err_d    = qto_err_q;
    sw_flag_d    = sw_flag_q;
    wait_cnt_d   = wait_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    rel_cnt_d    = rel_cnt_q;
    rel_dly_d    = rel_dly_q;
    rel_idx_d    = rel_idx_q;
    wait_inc     = wait_cnt_q + DLY_W'(1);

    case (state_q)
      S_IDLE: begin
        if (sw_rst_req) begin
          state_d    = S_QUIESCE;
          qto_err_d  = 1'b0;
          sw_flag_d  = 1'b1;
          wait_cnt_d = '0;
        end
      end
      S_QUIESCE: begin
        wait_cnt_d = wait_inc;
        // All-idle takes priority over a timeout landing on the same cycle.
        if (&part_idle) begin
          state_d     = S_ASSERT;
          part_rstn_d = '0;
        end else if ((cfg_qto != '0) && (wait_inc == cfg_qto)) begin
          state_d     = S_ASSERT;
          part_rstn_d = '0;
          qto_err_d   = 1'b1;
        end
      end
      S_ASSERT: begin
        state_d     = S_HOLD;
        part_rstn_d = '0;
        hold_cnt_d  = '0;
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          rel_dly_d      = cfg_rel_dly;
          rel_cnt_d      = '0;
          rel_idx_d      = IDX_W'(1);
          part_rstn_d[0] = 1'b1;
          state_d        = (NUM_PART == 1) ? S_DONE : S_RELEASE;
          sw_rst_ack_d   = (NUM_PART == 1) && sw_flag_q;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_RELEASE: begin
        if (rel_cnt_q == rel_dly_q) begin
          part_rstn_d[rel_idx_q] = 1'b1;
          rel_cnt_d              = '0;
          rel_idx_d              = rel_idx_q + IDX_W'(1);
          if (rel_idx_q == IDX_LAST) begin
            state_d      = S_DONE;
            sw_rst_ack_d = sw_flag_q;
          end
        end else begin
          rel_cnt_d = rel_cnt_q + DLY_W'(1);
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        sw_flag_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    seq_busy_d = (state_d != S_IDLE);
  end

  // Reset lands in HOLD so the power-on path reuses the normal hold/release sequence.
  always_ff @(posedge nvdla_clk) begin
    if (dla_reset) begin
      state_q      <= S_HOLD;
      part_rstn_q  <= '0;
      sw_rst_ack_q <= 1'b0;
      seq_busy_q   <= 1'b1;
      qto_err_q    <= 1'b0;
      sw_flag_q    <= 1'b0;
      wait_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      rel_cnt_q    <= '0;
      rel_dly_q    <= '0;
      rel_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      part_rstn_q  <= part_rstn_d;
      sw_rst_ack_q <= sw_rst_ack_d;
      seq_busy_q   <= seq_busy_d;
      qto_err_q    <= qto_err_d;
      sw_flag_q    <= sw_flag_d;
      wait_cnt_q   <= wait_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      rel_cnt_q    <= rel_cnt_d;
      rel_dly_q    <= rel_dly_d;
      rel_idx_q    <= rel_idx_d;
    end
  end

  assign part_rstn  = part_rstn_q;
  assign sw_rst_ack = sw_rst_ack_q;
  assign seq_busy   = seq_busy_q;
  assign qto_err    = qto_err_q;

endmodule

// File: tb/tb_nv_nvdla_reset_seq.sv
// Bench for nv_nvdla_reset_seq: schedule-based reference model checked every cycle, plus directed literal checks.
module tb_nv_nvdla_reset_seq;

  localparam int NP   = 4;
  localparam int DW   = 8;
  localparam int HOLD = 16;

  localparam int M_IDLE = 0;
  localparam int M_QUI  = 1;
  localparam int M_SEQ  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          dla_reset;
  logic          sw_rst_req;
  logic [DW-1:0] cfg_rel_dly;
  logic [DW-1:0] cfg_qto;
  logic [NP-1:0] part_idle;
  logic [NP-1:0] part_rstn;
  logic          sw_rst_ack;
  logic          seq_busy;
  logic          qto_err;

  int n_chk    = 0;
  int n_err    = 0;
  int ack_seen = 0;
  int a0;

  // Reference model: tracks the edge at which partition 0 releases and derives every output from it.
  int            n_edge  = 0;
  int            m_mode  = M_IDLE;
  bit            m_valid = 1'b0;
  int            m_q     = 0;
  int            m_base  = 0;
  int            m_sp    = 1;
  bit            m_sw    = 1'b0;
  bit            m_qerr  = 1'b0;
  logic [NP-1:0] m_rstn  = '0;
  bit            m_busy  = 1'b0;
  bit            m_ack   = 1'b0;

  nv_nvdla_reset_seq #(.NUM_PART(NP), .DLY_W(DW), .HOLD_CYC(HOLD)) dut (
    .nvdla_clk   (clk),
    .dla_reset   (dla_reset),
    .sw_rst_req  (sw_rst_req),
    .cfg_rel_dly (cfg_rel_dly),
    .cfg_qto     (cfg_qto),
    .part_idle   (part_idle),
    .part_rstn   (part_rstn),
    .sw_rst_ack  (sw_rst_ack),
    .seq_busy    (seq_busy),
    .qto_err     (qto_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    n_edge++;
    if (dla_reset) begin
      m_valid = 1'b1;
      m_mode  = M_SEQ;
      m_base  = n_edge + HOLD;
      m_sw    = 1'b0;
      m_qerr  = 1'b0;
    end else if (m_valid) begin
      case (m_mode)
        M_IDLE: if (sw_rst_req) begin
          m_mode = M_QUI; m_q = n_edge; m_qerr = 1'b0; m_sw = 1'b1;
        end
        M_QUI: begin
          if (&part_idle) begin
            m_mode = M_SEQ; m_base = n_edge + 1 + HOLD;
          end else if (cfg_qto != 0 && ((n_edge - m_q) % (1 << DW)) == int'(cfg_qto)) begin
            m_mode = M_SEQ; m_base = n_edge + 1 + HOLD; m_qerr = 1'b1;
          end
        end
        default: begin
          if (n_edge == m_base) m_sp = int'(cfg_rel_dly) + 1;
          if (n_edge > m_base && n_edge == m_base + (NP - 1) * m_sp + 1) begin
            m_mode = M_IDLE; m_sw = 1'b0;
          end
        end
      endcase
    end
    m_ack = 1'b0;
    case (m_mode)
      M_IDLE: begin m_rstn = '1; m_busy = 1'b0; end
      M_QUI:  begin m_rstn = '1; m_busy = 1'b1; end
      default: begin
        m_busy = 1'b1;
        for (int i = 0; i < NP; i++)
          m_rstn[i] = (n_edge >= m_base) && (n_edge >= m_base + i * m_sp);
        m_ack = m_sw && (n_edge >= m_base) && (n_edge == m_base + (NP - 1) * m_sp);
      end
    endcase
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk);
      model_step();
    end
  endtask

  task automatic cmp_loop();
    forever begin
      @(negedge clk);
      if (sw_rst_ack === 1'b1) ack_seen++;
      if (m_valid) begin
        chk("model part_rstn", 32'(part_rstn), 32'(m_rstn));
        chk("model seq_busy", 32'(seq_busy), 32'(m_busy));
        chk("model sw_rst_ack", 32'(sw_rst_ack), 32'(m_ack));
        chk("model qto_err", 32'(qto_err), 32'(m_qerr));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rstn(input logic [NP-1:0] v, input int maxc, input string nm);
    int k = 0;
    while (part_rstn !== v && k < maxc) begin tick(); k++; end
    n_chk++;
    if (part_rstn !== v) begin
      n_err++;
      $display("FAIL %s: timeout, part_rstn=%b, expected %b", nm, part_rstn, v);
    end
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int k = 0;
    while (seq_busy !== 1'b0 && k < maxc) begin tick(); k++; end
    n_chk++;
    if (seq_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s: timeout, seq_busy=%b, expected 0", nm, seq_busy);
    end
  endtask

  task automatic pulse_req();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
  endtask

  initial begin
    dla_reset   = 1'b1;
    sw_rst_req  = 1'b0;
    cfg_rel_dly = 8'd2;
    cfg_qto     = 8'd0;
    part_idle   = '0;
    fork
      model_loop();
      cmp_loop();
    join_none

    // Power-on
    repeat (3) tick();
    chk("reset part_rstn", 32'(part_rstn), 32'h0);
    chk("reset seq_busy", 32'(seq_busy), 32'h1);
    chk("reset sw_rst_ack", 32'(sw_rst_ack), 32'h0);
    chk("reset qto_err", 32'(qto_err), 32'h0);
    a0 = ack_seen;
    dla_reset = 1'b0;
    for (int k = 0; k < 26; k++) begin
      tick();
      case (k)
        14: chk("por hold end", 32'(part_rstn), 32'h0);
        15: chk("por bit0", 32'(part_rstn), 32'h1);
        17: chk("por spacing", 32'(part_rstn), 32'h1);
        18: chk("por bit1", 32'(part_rstn), 32'h3);
        21: chk("por bit2", 32'(part_rstn), 32'h7);
        24: begin
          chk("por bit3", 32'(part_rstn), 32'hF);
          chk("por busy in done", 32'(seq_busy), 32'h1);
        end
        25: chk("por busy fall", 32'(seq_busy), 32'h0);
        default: ;
      endcase
    end
    chk("por no ack", 32'(ack_seen - a0), 32'h0);

    // Soft reset, all idle
    part_idle = 4'hF;
    a0 = ack_seen;
    pulse_req();
    chk("soft quiesce rstn", 32'(part_rstn), 32'hF);
    chk("soft quiesce busy", 32'(seq_busy), 32'h1);
    tick();
    chk("soft assert rstn", 32'(part_rstn), 32'h0);
    wait_idle(200, "soft idle");
    chk("soft one ack", 32'(ack_seen - a0), 32'h1);
    chk("soft qto_err", 32'(qto_err), 32'h0);

    // Quiesce timeout
    part_idle = 4'h7;
    cfg_qto   = 8'd5;
    a0 = ack_seen;
    pulse_req();
    repeat (4) tick();
    chk("qto pre rstn", 32'(part_rstn), 32'hF);
    chk("qto pre err", 32'(qto_err), 32'h0);
    tick();
    chk("qto assert rstn", 32'(part_rstn), 32'h0);
    chk("qto err set", 32'(qto_err), 32'h1);
    wait_idle(200, "qto idle");
    repeat (3) tick();
    chk("qto err sticky", 32'(qto_err), 32'h1);
    chk("qto one ack", 32'(ack_seen - a0), 32'h1);

    // Indefinite wait, counter wraps past 2^DW
    cfg_qto   = 8'd0;
    part_idle = 4'h0;
    a0 = ack_seen;
    pulse_req();
    chk("indef err cleared", 32'(qto_err), 32'h0);
    repeat (300) tick();
    chk("indef still quiesce", 32'(part_rstn), 32'hF);
    chk("indef busy", 32'(seq_busy), 32'h1);
    part_idle = 4'hF;
    tick();
    chk("indef assert", 32'(part_rstn), 32'h0);
    wait_idle(200, "indef idle");
    chk("indef one ack", 32'(ack_seen - a0), 32'h1);
    chk("indef qto_err", 32'(qto_err), 32'h0);

    // Request during RELEASE is dropped
    cfg_rel_dly = 8'd2;
    a0 = ack_seen;
    pulse_req();
    wait_rstn(4'h1, 100, "busy bit0");
    pulse_req();
    wait_idle(200, "busy idle");
    repeat (2) tick();
    chk("busy one ack", 32'(ack_seen - a0), 32'h1);
    chk("busy not queued", 32'(seq_busy), 32'h0);

    // dla_reset mid-release
    a0 = ack_seen;
    pulse_req();
    wait_rstn(4'h3, 100, "midrst bit1");
    dla_reset = 1'b1;
    tick();
    chk("midrst rstn", 32'(part_rstn), 32'h0);
    chk("midrst busy", 32'(seq_busy), 32'h1);
    dla_reset = 1'b0;
    wait_idle(200, "midrst idle");
    chk("midrst no ack", 32'(ack_seen - a0), 32'h0);
    chk("midrst rstn done", 32'(part_rstn), 32'hF);

    // Held request re-accepted after DONE; cfg_rel_dly change after HOLD exit ignored
    cfg_rel_dly = 8'd1;
    a0 = ack_seen;
    sw_rst_req = 1'b1;
    tick();
    wait_rstn(4'h1, 100, "held bit0");
    cfg_rel_dly = 8'd7;
    wait_idle(200, "held idle");
    tick();
    chk("held reaccept", 32'(seq_busy), 32'h1);
    sw_rst_req = 1'b0;
    wait_idle(300, "held idle2");
    chk("held two acks", 32'(ack_seen - a0), 32'h2);

    // Maximum release spacing
    cfg_rel_dly = 8'hFF;
    a0 = ack_seen;
    pulse_req();
    wait_idle(1200, "max idle");
    chk("max one ack", 32'(ack_seen - a0), 32'h1);

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
